array_divider_16b8b: RTL and testbench

//  Pipelined restoring array divider: W-bit quotient and W-bit remainder of a 2W-bit dividend over a W-bit divisor.

---
 rtl/array_divider_16b8b.sv | 213 +++++++++++++++++++++
 tb/tb_array_divider_16b8b.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/array_divider_16b8b.sv
// Pipelined restoring array divider: 2W-bit dividend over W-bit divisor, one
// quotient bit per registered row, full throughput with a global advance enable.
module array_divider_16b8b #(
   parameter int W       = 8,
   parameter int REG_IN  = 1,
   parameter int REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_valid,
   input  logic [2*W-1:0]   i_dividend,
   input  logic [W-1:0]     i_divisor,
   output logic             o_valid,
   output logic [W-1:0]     o_quotient,
   output logic [W-1:0]     o_remainder,
   output logic             o_div0,
   output logic             o_ovf
);

   localparam int LATENCY = REG_IN + W + REG_OUT;
   localparam int ROWS    = LATENCY - REG_IN - REG_OUT;

   logic             s0_valid_s;
   logic [W-1:0]     s0_d_s;
   logic [W-1:0]     s0_hi_s;
   logic [W-1:0]     s0_lo_s;
   logic             s0_div0_s;
   logic             s0_ovf_s;

   generate
      if (REG_IN != 0) begin : g_reg_in
         logic         valid_r;
         logic [W-1:0] d_r;
         logic [W-1:0] hi_r;
         logic [W-1:0] lo_r;

         // Entry register; empty slots carry zero operands rather than stale data
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_r <= 1'b0;
               d_r     <= '0;
               hi_r    <= '0;
               lo_r    <= '0;
            end else if (i_en) begin
               valid_r <= i_valid;
               d_r     <= i_valid ? i_divisor : '0;
               hi_r    <= i_valid ? i_dividend[2*W-1:W] : '0;
               lo_r    <= i_valid ? i_dividend[W-1:0] : '0;
            end
         end

         assign s0_valid_s = valid_r;
         assign s0_d_s     = d_r;
         assign s0_hi_s    = hi_r;
         assign s0_lo_s    = lo_r;
      end else begin : g_comb_in
         assign s0_valid_s = i_valid;
         assign s0_d_s     = i_valid ? i_divisor : '0;
         assign s0_hi_s    = i_valid ? i_dividend[2*W-1:W] : '0;
         assign s0_lo_s    = i_valid ? i_dividend[W-1:0] : '0;
      end
   endgenerate

   // Exception flags are decided once at entry and ride along with the op
   assign s0_div0_s = s0_valid_s && (s0_d_s == '0);
   assign s0_ovf_s  = s0_valid_s && (s0_d_s != '0) && (s0_hi_s >= s0_d_s);

   logic             p_valid_r [ROWS];
   logic [W-1:0]     p_d_r     [ROWS];
   logic [W-1:0]     p_lo_r    [ROWS];
   logic [W-1:0]     p_r_r     [ROWS];
   logic [W-1:0]     p_q_r     [ROWS];
   logic             p_div0_r  [ROWS];
   logic             p_ovf_r   [ROWS];

   logic             in_valid_s [ROWS];
   logic [W-1:0]     in_d_s     [ROWS];
   logic [W-1:0]     in_lo_s    [ROWS];
   logic [W-1:0]     in_r_s     [ROWS];
   logic [W-1:0]     in_q_s     [ROWS];
   logic             in_div0_s  [ROWS];
   logic             in_ovf_s   [ROWS];

   logic             nx_valid_s [ROWS];
   logic [W-1:0]     nx_d_s     [ROWS];
   logic [W-1:0]     nx_lo_s    [ROWS];
   logic [W-1:0]     nx_r_s     [ROWS];
   logic [W-1:0]     nx_q_s     [ROWS];
   logic             nx_div0_s  [ROWS];
   logic             nx_ovf_s   [ROWS];

   // Row inputs: row 0 starts with r = high dividend half, later rows read the previous register
   always_comb begin
      in_valid_s[0] = s0_valid_s;
      in_d_s[0]     = s0_d_s;
      in_lo_s[0]    = s0_lo_s;
      in_r_s[0]     = s0_hi_s;
      in_q_s[0]     = '0;
      in_div0_s[0]  = s0_div0_s;
      in_ovf_s[0]   = s0_ovf_s;
      for (int k = 1; k < ROWS; k++) begin
         in_valid_s[k] = p_valid_r[k-1];
         in_d_s[k]     = p_d_r[k-1];
         in_lo_s[k]    = p_lo_r[k-1];
         in_r_s[k]     = p_r_r[k-1];
         in_q_s[k]     = p_q_r[k-1];
         in_div0_s[k]  = p_div0_r[k-1];
         in_ovf_s[k]   = p_ovf_r[k-1];
      end
   end

   // One restoring subtract/compare per row; the next dividend bit is the MSB of the shifted low half
   always_comb begin
      logic [W:0] rp_s;
      logic [W:0] diff_s;
      logic       ge_s;
      rp_s   = '0;
      diff_s = '0;
      ge_s   = 1'b0;
      for (int k = 0; k < ROWS; k++) begin
         rp_s          = {in_r_s[k], in_lo_s[k][W-1]};
         diff_s        = rp_s - {1'b0, in_d_s[k]};
         ge_s          = in_valid_s[k] && (rp_s >= {1'b0, in_d_s[k]});
         nx_valid_s[k] = in_valid_s[k];
         nx_d_s[k]     = in_d_s[k];
         nx_lo_s[k]    = {in_lo_s[k][W-2:0], 1'b0};
         nx_r_s[k]     = ge_s ? diff_s[W-1:0] : rp_s[W-1:0];
         nx_q_s[k]     = {in_q_s[k][W-2:0], ge_s};
         nx_div0_s[k]  = in_div0_s[k];
         nx_ovf_s[k]   = in_ovf_s[k];
      end
   end

   // Row registers, all advanced together by the global enable
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ROWS; k++) begin
            p_valid_r[k] <= 1'b0;
            p_d_r[k]     <= '0;
            p_lo_r[k]    <= '0;
            p_r_r[k]     <= '0;
            p_q_r[k]     <= '0;
            p_div0_r[k]  <= 1'b0;
            p_ovf_r[k]   <= 1'b0;
         end
      end else if (i_en) begin
         for (int k = 0; k < ROWS; k++) begin
            p_valid_r[k] <= nx_valid_s[k];
            p_d_r[k]     <= nx_d_s[k];
            p_lo_r[k]    <= nx_lo_s[k];
            p_r_r[k]     <= nx_r_s[k];
            p_q_r[k]     <= nx_q_s[k];
            p_div0_r[k]  <= nx_div0_s[k];
            p_ovf_r[k]   <= nx_ovf_s[k];
         end
      end
   end

   logic             fin_valid_s;
   logic [W-1:0]     fin_q_s;
   logic [W-1:0]     fin_r_s;
   logic             fin_div0_s;
   logic             fin_ovf_s;

   // Result shaping: saturate the quotient on exceptions, zero everything on empty slots
   always_comb begin
      fin_valid_s = p_valid_r[ROWS-1];
      fin_div0_s  = p_valid_r[ROWS-1] && p_div0_r[ROWS-1];
      fin_ovf_s   = p_valid_r[ROWS-1] && p_ovf_r[ROWS-1];
      if (!p_valid_r[ROWS-1]) begin
         fin_q_s = '0;
         fin_r_s = '0;
      end else if (p_ovf_r[ROWS-1]) begin
         fin_q_s = '1;
         fin_r_s = '0;
      end else if (p_div0_r[ROWS-1]) begin
         fin_q_s = '1;
         fin_r_s = p_r_r[ROWS-1];
      end else begin
         fin_q_s = p_q_r[ROWS-1];
         fin_r_s = p_r_r[ROWS-1];
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         // Output register, frozen with the rest of the pipe
         always_ff @(posedge clk) begin
            if (rst) begin
               o_valid     <= 1'b0;
               o_quotient  <= '0;
               o_remainder <= '0;
               o_div0      <= 1'b0;
               o_ovf       <= 1'b0;
            end else if (i_en) begin
               o_valid     <= fin_valid_s;
               o_quotient  <= fin_q_s;
               o_remainder <= fin_r_s;
               o_div0      <= fin_div0_s;
               o_ovf       <= fin_ovf_s;
            end
         end
      end else begin : g_comb_out
         assign o_valid     = fin_valid_s;
         assign o_quotient  = fin_q_s;
         assign o_remainder = fin_r_s;
         assign o_div0      = fin_div0_s;
         assign o_ovf       = fin_ovf_s;
      end
   endgenerate

endmodule

// File: tb/tb_array_divider_16b8b.sv
// Scoreboard bench for array_divider_16b8b: each accepted op queues its expected
// result and due enabled-edge; outputs are compared after every clock edge.
module tb_array_divider_16b8b;

   localparam int W   = 8;
   localparam int LAT = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_en;
   logic          i_valid;
   logic [15:0]   i_dividend;
   logic [7:0]    i_divisor;
   logic          o_valid;
   logic [7:0]    o_quotient;
   logic [7:0]    o_remainder;
   logic          o_div0;
   logic          o_ovf;

   array_divider_16b8b #(.W(W), .REG_IN(1), .REG_OUT(1)) dut (
      .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
      .i_dividend(i_dividend), .i_divisor(i_divisor),
      .o_valid(o_valid), .o_quotient(o_quotient), .o_remainder(o_remainder),
      .o_div0(o_div0), .o_ovf(o_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] n;
      logic [7:0]  d;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        div0;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          ecount   = 0;

   logic        ev  = 1'b0;
   logic [7:0]  eq  = 8'h00;
   logic [7:0]  er  = 8'h00;
   logic        ed0 = 1'b0;
   logic        eov = 1'b0;
   logic [15:0] cur_n = 16'h0000;
   logic [7:0]  cur_d = 8'h00;

   function automatic exp_t model(input logic [15:0] n, input logic [7:0] d);
      exp_t        e;
      logic [15:0] quo;
      logic [15:0] rem;
      e.n = n; e.d = d; e.div0 = 1'b0; e.ovf = 1'b0; e.due = 0;
      if (d == 8'h00) begin
         e.div0 = 1'b1; e.q = 8'hFF; e.r = n[7:0];
      end else if (n[15:8] >= d) begin
         e.ovf = 1'b1; e.q = 8'hFF; e.r = 8'h00;
      end else begin
         quo = n / {8'h00, d};
         rem = n % {8'h00, d};
         e.q = quo[7:0];
         e.r = rem[7:0];
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance, then update the expected output state and compare
   task automatic step(input logic r_i, input logic en_i, input logic v_i,
                       input logic [15:0] n_i, input logic [7:0] d_i);
      exp_t e;
      rst = r_i; i_en = en_i; i_valid = v_i; i_dividend = n_i; i_divisor = d_i;
      @(posedge clk);
      #1;
      if (r_i) begin
         sb.delete();
         ev = 1'b0; eq = 8'h00; er = 8'h00; ed0 = 1'b0; eov = 1'b0;
      end else if (en_i) begin
         ecount++;
         if (v_i) begin
            e = model(n_i, d_i);
            e.due = ecount + LAT - 1;
            sb.push_back(e);
         end
         if (sb.size() > 0 && sb[0].due == ecount) begin
            e = sb.pop_front();
            ev = 1'b1; eq = e.q; er = e.r; ed0 = e.div0; eov = e.ovf;
            cur_n = e.n; cur_d = e.d;
         end else begin
            ev = 1'b0; eq = 8'h00; er = 8'h00; ed0 = 1'b0; eov = 1'b0;
         end
      end
      chk("o_valid", {31'd0, o_valid}, {31'd0, ev});
      chk("o_quotient", {24'd0, o_quotient}, {24'd0, eq});
      chk("o_remainder", {24'd0, o_remainder}, {24'd0, er});
      chk("o_div0", {31'd0, o_div0}, {31'd0, ed0});
      chk("o_ovf", {31'd0, o_ovf}, {31'd0, eov});
      if (ev && !ed0 && !eov) begin
         chk("q*d+r==n", {24'd0, o_quotient} * {24'd0, cur_d} + {24'd0, o_remainder},
             {16'd0, cur_n});
         chk("r<d", {31'd0, (o_remainder < cur_d)}, 32'd1);
      end
   endtask

   task automatic op(input logic [15:0] n_i, input logic [7:0] d_i);
      step(1'b0, 1'b1, 1'b1, n_i, d_i);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(1'b0, 1'b1, 1'b0, 16'($urandom), 8'($urandom));
   endtask

   task automatic stall(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(1'b0, 1'b0, 1'b1, 16'($urandom), 8'($urandom));
   endtask

   initial begin
      logic [7:0]  rd;
      logic [15:0] rn;
      logic        ren;
      logic        rv;
      int          sel;

      step(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
      idle(2);

      op(16'd12345, 8'd100);
      op(16'd40000, 8'd200);
      idle(LAT + 1);

      op(16'hFF00, 8'h10);
      op(16'h1234, 8'h00);
      idle(LAT + 1);

      op(16'h0000, 8'h01);
      op(16'h00FF, 8'h01);
      op(16'hFEFF, 8'hFF);
      op(16'hFF00, 8'hFF);
      idle(LAT + 1);

      // Stall while ops are in flight, then again while a result sits on the outputs
      op(16'd1000, 8'd7);
      op(16'd65535 - 16'd256, 8'd255);
      op(16'd513, 8'd3);
      stall(3);
      op(16'd77, 8'd9);
      op(16'h0A0B, 8'h0C);
      idle(6);
      stall(3);
      idle(LAT);

      // Reset with ops in flight; nothing from before may emerge afterwards
      op(16'd500, 8'd5);
      op(16'd600, 8'd6);
      op(16'd700, 8'd7);
      op(16'd800, 8'd8);
      step(1'b1, 1'b1, 1'b1, 16'd900, 8'd9);
      op(16'd4321, 8'd17);
      idle(LAT + 2);

      for (int i = 0; i < 3000; i++) begin
         ren = ($urandom_range(0, 7) != 0);
         rv  = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 15);
         rd  = 8'($urandom_range(1, 255));
         if (sel == 0) rd = 8'h00;
         if (sel == 1 || rd == 8'h00)
            rn = 16'($urandom);
         else
            rn = {8'($urandom_range(0, int'(rd) - 1)), 8'($urandom)};
         step(1'b0, ren, rv, rn, rd);
      end
      idle(LAT + 2);

      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
